frame_scheduler: RTL
====================

Name: frame_scheduler

Overview:
- Per-frame controller for the game datapath.
- Detects the start of each frame from the vertical sync (switch_frame) and runs the game's update units (doodle physics, platform scroll, collision) one after another over a start/done handshake.
- Owns the top-level game state (TITLE/PLAY/OVER).
- Sits between beam_establisher and the update units in game, replacing free-running per-cycle updates with one ordered update pass per frame.

Parameters:
N_STAGES, 3, number of sequenced update units (stage 0 runs first)
TIMEOUT, 4096, max clk cycles a stage may take before being force-completed
OVER_FRAMES, 120, frames spent in OVER before returning to TITLE
FRAME_CNT_W, 16, width of frame counter

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
switch_frame  input  1  vertical sync from beam_establisher, low during the sync pulse
button_start  input  1  debounced level, high = pressed
clear_err  input  1  clears sticky error flags
game_over  input  1  level from collision logic, high = doodle lost
stage_done  input  N_STAGES  per-stage completion pulse
stage_start  output  N_STAGES  per-stage one-cycle start pulse, at most one bit high
new_game  output  1  one-cycle pulse on TITLE->PLAY; units reinitialise
game_state  output  2  TITLE=0, PLAY=1, OVER=2
busy  output  1  high while an update pass is in progress
frame_cnt  output  FRAME_CNT_W  frames seen since reset, wraps to 0
overrun  output  1  sticky: a frame started while the pass was still busy
timeout_err  output  1  sticky: a stage hit TIMEOUT

Behaviour:
- Reset (rst=0 at a clk edge):
  - Outputs: game_state=TITLE, sequencer=IDLE, stage_start=0, new_game=0, busy=0, frame_cnt=0, overrun=0, timeout_err=0.
  - Internal: vs_q=0, btn_q=0, timeout and over counters 0.
  - Reset mid-pass aborts the pass; no stage_start is issued afterwards.
- Frame tick: tick=vs_q & ~switch_frame, where vs_q is switch_frame registered.
  - With vs_q=0 after reset, no tick fires until switch_frame has been seen high.
  - frame_cnt increments on every tick in every game state and wraps modulo 2^FRAME_CNT_W.
- Button edge: press = button_start & ~btn_q.
- Sequencer FSM (active only in PLAY):
  - IDLE: on tick, go to ISSUE with stage index i=0. busy=0 only in IDLE.
  - ISSUE (1 cycle): stage_start[i]=1, then go to WAIT and clear the timeout counter. Latency: stage_start[0] is high exactly 1 cycle after the tick cycle.
  - WAIT:
    - stage_done[i] is accepted only here. stage_done during ISSUE or for other indices is ignored.
    - On done, or when the counter reaches TIMEOUT-1: if i<N_STAGES-1, go to ISSUE with i+1; otherwise go to EVAL.
    - A timeout sets timeout_err.
  - EVAL (1 cycle): sample game_over. If 1, game_state becomes OVER and the over counter is cleared. Then go to IDLE.
  - Consecutive stages: done at cycle T gives stage_start[i+1] at T+1.
- Overrun: a tick while busy=1 sets overrun. That tick is dropped and the current pass continues.
- Game FSM:
  - TITLE: press -> PLAY, with new_game=1 in the first PLAY cycle.
  - PLAY: presses ignored; leaves only via EVAL.
  - OVER: each tick increments the over counter. When it reaches OVER_FRAMES -> TITLE. Presses ignored in OVER.
- Sticky flags: cleared by clear_err=1. If set and clear happen in the same cycle, set wins.
- Leaving PLAY only happens from EVAL, so no pass is ever left dangling.

Decomposition:
- Package game_pkg:
  - game_state_t enum (TITLE, PLAY, OVER).
  - seq_state_t enum (IDLE, ISSUE, WAIT, EVAL).
  - Shared constants for FRAME_CNT_W defaults.
- One sub-module, edge_detect (registered rising/falling detector with synchronous active-low reset), instantiated twice: for switch_frame (falling) and button_start (rising).

Test Plan:
- Release rst with switch_frame=0, then pulse switch_frame 1->0 -> no tick before the first high level; frame_cnt=1 after the first falling edge; game_state stays TITLE.
- TITLE, press at cycle 10 -> game_state=PLAY and new_game=1 at cycle 11, for one cycle only.
- PLAY, tick at T; done[0] at T+5, done[1] at T+8, done[2] at T+12 -> stage_start[0]@T+1, [1]@T+6, [2]@T+9; EVAL@T+13; IDLE and busy=0 @T+14.
- PLAY, stage 1 never signals done, TIMEOUT=16 -> timeout_err=1, stage_start[2] 17 cycles after stage_start[1]; clear_err on the same cycle as the timeout leaves the flag at 1.
- Second tick while stage 0 is still in WAIT -> overrun=1, frame_cnt still increments, stage 0 not reissued.
- game_over=1 at EVAL -> OVER; after OVER_FRAMES=3 ticks -> TITLE; a press during OVER is ignored.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state encodings and sizing helpers for the per-frame game controller.
package game_pkg;

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } game_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EVAL  = 2'd3
    } seq_state_t;

    localparam int DEF_N_STAGES    = 3;
    localparam int DEF_TIMEOUT     = 4096;
    localparam int DEF_OVER_FRAMES = 120;
    localparam int DEF_FRAME_CNT_W = 16;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// One-register edge detector: flags a rising (RISING=1) or falling (RISING=0)
// transition of d in the cycle the new level is present.
module edge_detect #(
    parameter bit RISING = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic det
);

    logic d_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_reg <= 1'b0;
        end else begin
            d_reg <= d;
        end
    end

    assign det = RISING ? (d & ~d_reg) : (d_reg & ~d);

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame controller: one ordered start/done pass over the update units per
// vertical sync while playing, plus the TITLE/PLAY/OVER game state.
module frame_scheduler
    import game_pkg::*;
#(
    parameter int N_STAGES    = DEF_N_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int OVER_FRAMES = DEF_OVER_FRAMES,
    parameter int FRAME_CNT_W = DEF_FRAME_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   switch_frame,
    input  logic                   button_start,
    input  logic                   clear_err,
    input  logic                   game_over,
    input  logic [N_STAGES-1:0]    stage_done,
    output logic [N_STAGES-1:0]    stage_start,
    output logic                   new_game,
    output logic [1:0]             game_state,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   overrun,
    output logic                   timeout_err
);

    localparam int IDX_W = clog2_min1(N_STAGES);
    localparam int TO_W  = clog2_min1(TIMEOUT);
    localparam int OV_W  = clog2_min1(OVER_FRAMES);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STAGES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [OV_W-1:0]  OV_LAST  = OV_W'(OVER_FRAMES - 1);

    logic tick;
    logic press;

    game_state_t             game_state_reg;
    seq_state_t              seq_state_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [TO_W-1:0]         to_cnt_reg;
    logic [OV_W-1:0]         over_cnt_reg;
    logic [N_STAGES-1:0]     stage_start_reg;
    logic                    new_game_reg;
    logic                    busy_reg;
    logic [FRAME_CNT_W-1:0]  frame_cnt_reg;
    logic                    overrun_reg;
    logic                    timeout_err_reg;

    edge_detect #(.RISING(1'b0)) u_vsync_edge (
        .clk (clk),
        .rst (rst),
        .d   (switch_frame),
        .det (tick)
    );

    edge_detect #(.RISING(1'b1)) u_button_edge (
        .clk (clk),
        .rst (rst),
        .d   (button_start),
        .det (press)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            game_state_reg  <= TITLE;
            seq_state_reg   <= IDLE;
            idx_reg         <= '0;
            to_cnt_reg      <= '0;
            over_cnt_reg    <= '0;
            stage_start_reg <= '0;
            new_game_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            frame_cnt_reg   <= '0;
            overrun_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            stage_start_reg <= '0;
            new_game_reg    <= 1'b0;

            if (tick) begin
                frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
            end

            // Clear first so a same-cycle set below takes priority.
            if (clear_err) begin
                overrun_reg     <= 1'b0;
                timeout_err_reg <= 1'b0;
            end
            if (tick && busy_reg) begin
                overrun_reg <= 1'b1;
            end

            case (game_state_reg)
                TITLE: begin
                    if (press) begin
                        game_state_reg <= PLAY;
                        new_game_reg   <= 1'b1;
                    end
                end
                OVER: begin
                    if (tick) begin
                        if (over_cnt_reg == OV_LAST) begin
                            game_state_reg <= TITLE;
                            over_cnt_reg   <= '0;
                        end else begin
                            over_cnt_reg <= over_cnt_reg + OV_W'(1);
                        end
                    end
                end
                default: ;
            endcase

            // The sequencer only leaves IDLE in PLAY, and PLAY is only left from EVAL.
            case (seq_state_reg)
                IDLE: begin
                    if (tick && game_state_reg == PLAY) begin
                        seq_state_reg      <= ISSUE;
                        idx_reg            <= '0;
                        stage_start_reg[0] <= 1'b1;
                        busy_reg           <= 1'b1;
                    end
                end
                ISSUE: begin
                    seq_state_reg <= WAIT;
                    to_cnt_reg    <= '0;
                end
                WAIT: begin
                    if (stage_done[idx_reg] || to_cnt_reg == TO_LAST) begin
                        if (!stage_done[idx_reg]) begin
                            timeout_err_reg <= 1'b1;
                        end
                        if (idx_reg == IDX_LAST) begin
                            seq_state_reg <= EVAL;
                        end else begin
                            seq_state_reg                       <= ISSUE;
                            idx_reg                             <= idx_reg + IDX_W'(1);
                            stage_start_reg[idx_reg + IDX_W'(1)] <= 1'b1;
                        end
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                end
                EVAL: begin
                    if (game_over) begin
                        game_state_reg <= OVER;
                        over_cnt_reg   <= '0;
                    end
                    seq_state_reg <= IDLE;
                    busy_reg      <= 1'b0;
                end
                default: seq_state_reg <= IDLE;
            endcase
        end
    end

    assign stage_start = stage_start_reg;
    assign new_game    = new_game_reg;
    assign game_state  = game_state_reg;
    assign busy        = busy_reg;
    assign frame_cnt   = frame_cnt_reg;
    assign overrun     = overrun_reg;
    assign timeout_err = timeout_err_reg;

endmodule
